// File: rtl/mul_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
// Contents:
//   state_e         - arbiter FSM state encoding
//   gw_f            - grant index width for a given requester count
//   timeout_default - default watchdog limit for a given operand width
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    function automatic int gw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int timeout_default(input int dwidth);
        return 2 * dwidth + 8;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i  - request vector
//   last_i - index of the most recently served requester
//   gnt_o  - one-hot grant (first request found after last_i, wrapping)
//   idx_o  - binary index of the granted requester
//   any_o  - at least one request is pending
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [GW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [GW-1:0]   idx_o,
    output logic            any_o
);

    logic          found;
    logic [GW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        // Search starts one past the last winner so the previous winner
        // is considered last.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = GW'((32'(last_i) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one multi-cycle multiplier (pulse in / pulse out, no ready)
// among NREQ requesters with per-operation round-robin arbitration.
// Operands are latched on accept and held until the next accept; the
// product is returned to the winner with a one-hot rsp_valid strobe.
// A watchdog aborts an operation that sees no mul_o_valid within
// TIMEOUT WAIT cycles and responds with rsp_err=1, rsp_z=0.
// Ports:
//   clk, rstn            - clock, synchronous active-low reset
//   req_valid/x/y        - per-requester request and flattened operands
//   req_ready            - one-hot accept strobe (combinational, IDLE only)
//   rsp_valid/z/err      - one-hot response strobe, product, timeout flag
//   mul_i_valid/x/y      - start pulse and operands to the multiplier
//   mul_o_valid/z        - done pulse and product from the multiplier
//   busy                 - FSM not in IDLE
module mul_share_arbiter
    import mul_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DWIDTH  = 8,
    parameter int OWIDTH  = 2 * DWIDTH,
    parameter int TIMEOUT = timeout_default(DWIDTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_x,
    input  logic [NREQ*DWIDTH-1:0]   req_y,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [OWIDTH-1:0]        rsp_z,
    output logic                     rsp_err,
    output logic                     mul_i_valid,
    output logic [DWIDTH-1:0]        mul_x,
    output logic [DWIDTH-1:0]        mul_y,
    input  logic                     mul_o_valid,
    input  logic [OWIDTH-1:0]        mul_z,
    output logic                     busy
);

    localparam int GW = gw_f(NREQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e            state_q;
    logic [GW-1:0]     grant_q;
    logic [GW-1:0]     last_q;
    logic [CW-1:0]     cnt_q;
    logic [DWIDTH-1:0] mx_q;
    logic [DWIDTH-1:0] my_q;
    logic [OWIDTH-1:0] z_q;
    logic              err_q;
    logic              ivalid_q;
    logic [NREQ-1:0]   rspv_q;

    logic [NREQ-1:0]   arb_gnt;
    logic [GW-1:0]     arb_idx;
    logic              arb_any;
    logic [NREQ-1:0]   grant_1h;

    logic [DWIDTH-1:0] xs [NREQ];
    logic [DWIDTH-1:0] ys [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign xs[i] = req_x[i*DWIDTH +: DWIDTH];
        assign ys[i] = req_y[i*DWIDTH +: DWIDTH];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .GW   (GW)
    ) u_arb (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    assign grant_1h = NREQ'(1) << grant_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= GW'(NREQ - 1);
            cnt_q    <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            z_q      <= '0;
            err_q    <= 1'b0;
            ivalid_q <= 1'b0;
            rspv_q   <= '0;
        end else begin
            ivalid_q <= 1'b0;
            rspv_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        grant_q  <= arb_idx;
                        mx_q     <= xs[arb_idx];
                        my_q     <= ys[arb_idx];
                        ivalid_q <= 1'b1;  // start pulse is high during ISSUE
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    // A done pulse in the final watchdog cycle still counts
                    // as a normal completion.
                    if (mul_o_valid) begin
                        z_q     <= mul_z;
                        err_q   <= 1'b0;
                        rspv_q  <= grant_1h;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        z_q     <= '0;
                        err_q   <= 1'b1;
                        rspv_q  <= grant_1h;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    last_q  <= grant_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE) ? arb_gnt : '0;
    assign rsp_valid   = rspv_q;
    assign rsp_z       = z_q;
    assign rsp_err     = err_q;
    assign mul_i_valid = ivalid_q;
    assign mul_x       = mx_q;
    assign mul_y       = my_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter with a behavioural companion multiplier.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int OW   = 2 * DW;
    localparam int TO   = 2 * DW + 8;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*DW-1:0]   req_x = '0;
    logic [NREQ*DW-1:0]   req_y = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [OW-1:0]        rsp_z;
    logic                 rsp_err;
    logic                 mul_i_valid;
    logic [DW-1:0]        mul_x;
    logic [DW-1:0]        mul_y;
    logic                 mul_o_valid;
    logic [OW-1:0]        mul_z;
    logic                 busy;

    mul_share_arbiter #(
        .NREQ    (NREQ),
        .DWIDTH  (DW),
        .OWIDTH  (OW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_z       (rsp_z),
        .rsp_err     (rsp_err),
        .mul_i_valid (mul_i_valid),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_o_valid (mul_o_valid),
        .mul_z       (mul_z),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Companion multiplier: samples operands the cycle after i_valid,
    // pulses o_valid DW+2 cycles after i_valid.
    int unsigned   m_cnt = 0;
    logic          m_ov = 1'b0;
    logic [OW-1:0] m_z = '0;
    logic [DW-1:0] m_x = '0;
    logic [DW-1:0] m_y = '0;
    logic          hang = 1'b0;
    logic          stray = 1'b0;
    localparam logic [OW-1:0] STRAY_Z = 16'hBEEF;

    always @(posedge clk) begin
        if (!rstn) begin
            m_cnt <= 0;
            m_ov  <= 1'b0;
        end else begin
            m_ov <= 1'b0;
            if (mul_i_valid) begin
                m_cnt <= DW + 1;
            end else if (m_cnt != 0) begin
                if (m_cnt == DW + 1) begin
                    m_x <= mul_x;
                    m_y <= mul_y;
                end
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1 && !hang) begin
                    m_ov <= 1'b1;
                    m_z  <= OW'(m_x) * OW'(m_y);
                end
            end
        end
    end

    assign mul_o_valid = m_ov | stray;
    assign mul_z       = stray ? STRAY_Z : m_z;

    typedef struct {
        int unsigned   idx;
        logic [OW-1:0] z;
        logic          err;
        int unsigned   lat;
        int unsigned   cyc;
    } exp_t;

    exp_t          sb[$];
    int unsigned   gnt_log[$];
    int            tests = 0;
    int            fails = 0;
    int unsigned   cyc = 0;
    logic          keep = 1'b0;
    logic          race = 1'b0;
    logic          scramble = 1'b0;
    logic          iv_exp = 1'b0;
    logic [DW-1:0] cur_x = '0;
    logic [DW-1:0] cur_y = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
        req_x[i*DW +: DW] = x;
        req_y[i*DW +: DW] = y;
        req_valid[i] = 1'b1;
    endtask

    // One clock: checks at negedge, request drop/scramble after posedge.
    task automatic tick();
        int   g;
        exp_t e;
        g = -1;
        @(negedge clk);
        cyc++;
        check("mul_i_valid", 32'(mul_i_valid), 32'(iv_exp));
        iv_exp = 1'b0;
        if (busy) begin
            check("mul_x_hold", 32'(mul_x), 32'(cur_x));
            check("mul_y_hold", 32'(mul_y), 32'(cur_y));
        end
        if (sb.size() == 0) begin
            check("no_rsp", 32'(rsp_valid), 32'd0);
        end else if (rsp_valid != '0) begin
            e = sb.pop_front();
            check("rsp_valid", 32'(rsp_valid), 32'd1 << e.idx);
            check("rsp_z", 32'(rsp_z), 32'(e.z));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            check("rsp_latency", cyc - e.cyc, e.lat);
        end
        if (req_ready != '0) begin
            check("ready_onehot", 32'($countones(req_ready)), 32'd1);
            for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
            check("ready_has_req", 32'(req_valid[g]), 32'd1);
            gnt_log.push_back(g);
            cur_x = req_x[g*DW +: DW];
            cur_y = req_y[g*DW +: DW];
            e.idx = g;
            e.cyc = cyc;
            if (race) begin
                e.z = STRAY_Z; e.err = 1'b0; e.lat = TO + 2;
            end else if (hang) begin
                e.z = '0; e.err = 1'b1; e.lat = TO + 2;
            end else begin
                e.z = OW'(cur_x) * OW'(cur_y); e.err = 1'b0; e.lat = DW + 4;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            iv_exp = 1'b1;
            if (!keep) req_valid[g] = 1'b0;
        end
        if (scramble) begin
            for (int i = 0; i < NREQ; i++) begin
                req_x[i*DW +: DW] = DW'($urandom_range(255));
                req_y[i*DW +: DW] = DW'($urandom_range(255));
            end
        end
    endtask

    task automatic drain(input int unsigned maxc);
        int unsigned n = 0;
        while ((sb.size() != 0 || req_valid != '0 || busy) && n < maxc) begin
            tick();
            n++;
        end
        check("drain_bound", 32'(n < maxc), 32'd1);
    endtask

    task automatic wait_accept(input int unsigned maxc);
        int unsigned n = 0;
        int unsigned start = gnt_log.size();
        while (gnt_log.size() == start && n < maxc) begin
            tick();
            n++;
        end
        check("accept_bound", 32'(n < maxc), 32'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        sb.delete();
        gnt_log.delete();
        iv_exp = 1'b0;
        keep = 1'b0;
        hang = 1'b0;
        race = 1'b0;
        scramble = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mul_i_valid", 32'(mul_i_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_z", 32'(rsp_z), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mul_xy", {16'd0, mul_x, mul_y}, 32'd0);

        // Single request on requester 1
        set_req(1, 8'd13, 8'd11);
        drain(100);
        check("single_grant_cnt", gnt_log.size(), 32'd1);
        if (gnt_log.size() >= 1) check("single_grant", gnt_log[0], 32'd1);

        // Two simultaneous requests from reset: 0 before 2
        do_reset();
        set_req(0, 8'd3, 8'd5);
        set_req(2, 8'd200, 8'd2);
        drain(100);
        check("pair_grant_cnt", gnt_log.size(), 32'd2);
        if (gnt_log.size() >= 2) begin
            check("pair_first", gnt_log[0], 32'd0);
            check("pair_second", gnt_log[1], 32'd2);
        end

        // All requesters continuously, max operands
        do_reset();
        keep = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'd255, 8'd255);
        for (int unsigned n = 0; gnt_log.size() < 8 && n < 300; n++) tick();
        keep = 1'b0;
        req_valid = '0;
        drain(100);
        check("rr_grant_cnt", gnt_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++)
            check($sformatf("rr_order_%0d", i), gnt_log[i], 32'(i % NREQ));

        // Watchdog abort, late pulse ignored
        hang = 1'b1;
        set_req(3, 8'd9, 8'd9);
        drain(100);
        hang = 1'b0;
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (4) tick();
        check("stray_busy", 32'(busy), 32'd0);

        // Done pulse in the final watchdog cycle wins over the abort
        hang = 1'b1;
        race = 1'b1;
        set_req(0, 8'd7, 8'd9);
        wait_accept(50);
        race = 1'b0;
        repeat (TO) tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        hang = 1'b0;
        drain(50);

        // Normal operation resumes
        set_req(2, 8'd100, 8'd3);
        drain(100);

        // Operands scrambled while the operation runs
        set_req(2, 8'h5A, 8'hC3);
        wait_accept(50);
        scramble = 1'b1;
        drain(100);
        scramble = 1'b0;

        // Reset during WAIT
        gnt_log.delete();
        set_req(1, 8'd21, 8'd4);
        wait_accept(50);
        repeat (4) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        sb.delete();
        iv_exp = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (15) tick();
        gnt_log.delete();
        set_req(0, 8'd6, 8'd7);
        set_req(3, 8'd8, 8'd9);
        drain(100);
        check("post_rst_cnt", gnt_log.size(), 32'd2);
        if (gnt_log.size() >= 2) begin
            check("post_rst_first", gnt_log[0], 32'd0);
            check("post_rst_second", gnt_log[1], 32'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        check("global_time_limit", 32'd0, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one multi-cycle shift-add multiplier (i_valid/o_valid pulse interface, no ready) among NREQ requesters.
- Round-robin arbitration per operation; issues one operation at a time and holds operands stable while it runs.
- Returns the product to the winning requester, tagged by one-hot rsp_valid.
- Watchdog aborts a hung operation with an error response; sits between client blocks and the multiplier instance.

Parameters:
- NREQ, 4, number of requesters (>=2)
- DWIDTH, 8, operand width; must match the multiplier
- OWIDTH, 2*DWIDTH, product width
- TIMEOUT, 2*DWIDTH+8, max WAIT cycles before abort (> DWIDTH+2)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  NREQ  per-requester request; held until accepted
- req_x  in  NREQ*DWIDTH  flattened X operands; slice i = [i*DWIDTH +: DWIDTH]
- req_y  in  NREQ*DWIDTH  flattened Y operands
- req_ready  out  NREQ  one-hot accept strobe
- rsp_valid  out  NREQ  one-hot 1-cycle response strobe
- rsp_z  out  OWIDTH  product (0 on error)
- rsp_err  out  1  timeout flag, qualified by rsp_valid
- mul_i_valid  out  1  start pulse to multiplier
- mul_x  out  DWIDTH  operand X to multiplier
- mul_y  out  DWIDTH  operand Y to multiplier
- mul_o_valid  in  1  multiplier done pulse
- mul_z  in  OWIDTH  multiplier product
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rstn low at clk edge): state=IDLE, last_grant=NREQ-1, all outputs 0, WAIT counter 0. Reset mid-operation aborts with no response; the multiplier shares rstn.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick the first set bit searching from last_grant+1 modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle.
  - At the edge: latch grant g, mul_x<=req_x[g], mul_y<=req_y[g]; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE: mul_i_valid=1 for exactly this cycle; clear counter; go to WAIT.
- WAIT:
  - If mul_o_valid: rsp_z<=mul_z, rsp_err<=0, go to RESP.
  - Else if counter==TIMEOUT-1: rsp_z<=0, rsp_err<=1, go to RESP.
  - Else counter++.
  - mul_o_valid and timeout in the same cycle: mul_o_valid wins.
- RESP: rsp_valid[g]=1 for one cycle; last_grant<=g; go to IDLE. rsp_z and rsp_err hold until the next RESP.
- mul_x and mul_y change only on accept, so they are stable from ISSUE through RESP. The multiplier samples operands the cycle after i_valid.
- mul_o_valid outside WAIT (stray or late after a timeout) is ignored.
- Latency with the companion multiplier (o_valid DWIDTH+2 cycles after i_valid):
  - accept edge A, ISSUE A+1, mul_o_valid A+DWIDTH+3, rsp_valid A+DWIDTH+4 (12 cycles for DWIDTH=8).
  - Throughput: one operation per DWIDTH+5 cycles.
- Fairness: a continuously requesting client waits at most NREQ-1 operations.
- Width rules:
  - grant index width GW = max(1, $clog2(NREQ)).
  - Counter width = $clog2(TIMEOUT)+1.
  - No arithmetic on data; the product passes through unmodified.

Decomposition:
- Package mul_arb_pkg holds:
  - state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11
  - GW helper function
  - default TIMEOUT expression
- One sub-module: rr_arbiter (combinational). Inputs: request vector and last_grant. Outputs: one-hot grant, index, any.
- FSM, operand/result registers and watchdog stay in mul_share_arbiter.

Test Plan:
- Single request, req_valid[1] with x=13, y=11 -> req_ready[1] same cycle; mul_i_valid 1 cycle later; rsp_valid[1] 12 cycles after accept; rsp_z=143; rsp_err=0.
- req_valid[0] and req_valid[2] together from reset, x0=3, y0=5, x2=200, y2=2 -> req0 served first (rsp_z=15), then req2 (rsp_z=400); no overlap of mul_i_valid.
- All four requesting continuously for 8 operations -> grant order 0,1,2,3,0,1,2,3; max operands 255*255 -> rsp_z=65025 each.
- Hold mul_o_valid low -> rsp_valid[g] with rsp_err=1 and rsp_z=0 after TIMEOUT WAIT cycles; a late mul_o_valid pulse is ignored; the next request proceeds normally.
- Change req_x/req_y of the granted requester every cycle during WAIT -> mul_x/mul_y remain at the accepted values until the next accept.
- Assert rstn low during WAIT -> no rsp_valid; busy=0 after the edge; the next simultaneous req0/req3 grants req0 first.
